sync_width_fifo: RTL
====================

SYNC_WIDTH_FIFO -- requirements
Module: sync_width_fifo

Interface
REQ-001 SHALL have parameter WR_DATA_WIDTH, default 8: write word width.
REQ-002 SHALL have parameter RD_DATA_WIDTH, default 16: read word width; the ratio N = max/min of WR_DATA_WIDTH and RD_DATA_WIDTH is 1, 2 or 4, otherwise elaboration fails.
REQ-003 SHALL have parameter DEPTH_WIDTH, default 4: storage holds DEPTH = 2^DEPTH_WIDTH wide words, each max(WR,RD) bits.
REQ-004 SHALL have parameter ALMOST_FULL_NUM, default 12: threshold in stored wide words.
REQ-005 SHALL have parameter ALMOST_EMPTY_NUM, default 2: threshold in stored wide words.
REQ-006 SHALL have ports, clock and reset first: clk in 1 (single clock); rst in 1 (synchronous, active-high).
REQ-007 SHALL have ports: wr_en in 1; wr_data in WR_DATA_WIDTH; wr_full out 1; almost_full out 1; wr_water_level out DEPTH_WIDTH+log2(N)+1 (write-word units).
REQ-008 SHALL have ports: rd_en in 1; rd_data out RD_DATA_WIDTH; rd_empty out 1; almost_empty out 1; rd_water_level out DEPTH_WIDTH+log2(N)+1 (read-word units).
REQ-009 SHALL have ports: flush in 1 (discard contents); overflow out 1, sticky; underflow out 1, sticky.

Function
REQ-010 SHALL track E = count of stored wide words, 0..DEPTH; wr/rd pointers wrap modulo DEPTH.
REQ-011 SHALL, in upsize mode (WR<RD), pack N write words into one wide word, the first written word in the LSBs; the wide word commits to storage in the cycle the Nth word is accepted.
REQ-012 SHALL, in downsize mode (WR>RD), present slices of the head wide word LSB-first; the entry pops in the cycle its Nth slice is read.
REQ-013 SHALL, when N=1, act as a plain FIFO with no packing or unpacking.
REQ-014 SHALL drive wr_full = (E==DEPTH) and rd_empty = (E==0), combinationally from registered state; partially packed words are not readable.
REQ-015 SHALL drive almost_full = (E >= ALMOST_FULL_NUM) and almost_empty = (E <= ALMOST_EMPTY_NUM).
REQ-016 SHALL report, in upsize mode, wr_water_level = E*N + pack_count and rd_water_level = E.
REQ-017 SHALL report, in downsize mode, wr_water_level = E and rd_water_level = E*N - slice_offset.
REQ-018 SHALL accept a write only when wr_en=1 and wr_full=0; wr_en=1 with wr_full=1 is dropped and sets overflow, even if rd_en frees space in the same cycle.
REQ-019 SHALL accept a read only when rd_en=1 and rd_empty=0; rd_en=1 with rd_empty=1 sets underflow and leaves rd_data unchanged.
REQ-020 SHALL register rd_data: the word/slice for an accepted read appears the cycle after rd_en and holds until the next accepted read.
REQ-021 SHALL update E correctly on a simultaneous accepted commit and pop (net unchanged), including at E==DEPTH-1 and E==1.
REQ-022 SHALL, on flush=1, clear pointers, E, pack_count, slice_offset, overflow and underflow at the next edge, ignoring wr_en/rd_en that cycle; rd_data holds its value.
REQ-023 SHALL keep overflow and underflow set until rst or flush.

Reset
REQ-024 SHALL, with rst=1 at a clk edge, clear pointers, E, pack_count, slice_offset, overflow and underflow; rd_data=0, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, levels=0.
REQ-025 SHALL give rst priority over flush, wr_en and rd_en; reset mid-pack discards the partial word.
REQ-026 SHALL leave storage RAM contents uninitialised by reset; no output depends on them until written.

Verification
REQ-027 SHALL cover: default params, write 0x11,0x22 then rd_en -> rd_data=0x2211 one cycle later; wr_water_level 1 then 2, rd_water_level 1.
REQ-028 SHALL cover: write 32 bytes with no reads -> wr_full=1 after the 32nd, almost_full=1 from E=12; a 33rd write sets overflow and the contents are unchanged.
REQ-029 SHALL cover: WR=16, RD=8, write 0xA1B2 then read twice -> 0xB2 then 0xA1; rd_empty=1 after the second read.
REQ-030 SHALL cover: at E=16, rd_en and wr_en together -> read accepted, write dropped, overflow=1, E=15.
REQ-031 SHALL cover: rd_en on empty -> underflow=1, rd_data unchanged; then flush -> underflow=0, all levels 0.
REQ-032 SHALL cover: rst asserted with 1 byte pending in the packer -> after reset wr_water_level=0; next two writes 0x33,0x44 read back as 0x4433.

Source files
------------

// File: rtl/sync_width_fifo.sv
// Single-clock FIFO with write/read width conversion (ratio 1, 2 or 4).
// Narrow writes are packed LSB-first into wide words; wide words are read back as LSB-first slices.
module sync_width_fifo #(
  parameter int WR_DATA_WIDTH    = 8,
  parameter int RD_DATA_WIDTH    = 16,
  parameter int DEPTH_WIDTH      = 4,
  parameter int ALMOST_FULL_NUM  = 12,
  parameter int ALMOST_EMPTY_NUM = 2,
  localparam int MAX_W = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
  localparam int MIN_W = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? RD_DATA_WIDTH : WR_DATA_WIDTH,
  localparam int N     = MAX_W / MIN_W,
  localparam int LOG_N = (N == 4) ? 2 : ((N == 2) ? 1 : 0),
  localparam int LW    = DEPTH_WIDTH + LOG_N + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [LW-1:0]            wr_water_level,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [LW-1:0]            rd_water_level,
  input  logic                     flush,
  output logic                     overflow,
  output logic                     underflow
);

  localparam bit UPSIZE   = WR_DATA_WIDTH < RD_DATA_WIDTH;
  localparam bit DOWNSIZE = WR_DATA_WIDTH > RD_DATA_WIDTH;
  localparam int WN       = UPSIZE ? N : 1;    // write words per stored word
  localparam int RN       = DOWNSIZE ? N : 1;  // read slices per stored word
  localparam int CW       = (LOG_N > 0) ? LOG_N : 1;
  localparam int DEPTH    = 1 << DEPTH_WIDTH;

  localparam logic [CW-1:0]          WN_LAST = CW'(WN - 1);
  localparam logic [CW-1:0]          RN_LAST = CW'(RN - 1);
  localparam logic [DEPTH_WIDTH:0]   DEPTH_E = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   AF_TH   = (DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0]   AE_TH   = (DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

  if (!((N == 1 || N == 2 || N == 4) && (MAX_W % MIN_W == 0))) begin : g_bad_ratio
    $error("sync_width_fifo: width ratio must be 1, 2 or 4");
  end

  logic [MAX_W-1:0]         mem [DEPTH];

  logic [DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]     count_q, count_d;
  logic [CW-1:0]            pack_cnt_q, pack_cnt_d;
  logic [CW-1:0]            slice_q, slice_d;
  logic [MAX_W-1:0]         pack_buf_q, pack_buf_d;
  logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;

  logic                     full, empty;
  logic                     wr_acc, rd_acc, commit, pop;
  logic [MAX_W-1:0]         commit_word;
  logic [MAX_W-1:0]         head_word;
  logic [RD_DATA_WIDTH-1:0] head_slice;
  logic [LW-1:0]            scaled_count;

  assign full  = (count_q == DEPTH_E);
  assign empty = (count_q == '0);

  // Flush wins over both ports; full/empty are judged on the pre-edge count only.
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;
  assign commit = wr_acc & (pack_cnt_q == WN_LAST);
  assign pop    = rd_acc & (slice_q == RN_LAST);

  assign head_word = mem[rd_ptr_q];

  always_comb begin
    commit_word = pack_buf_q;
    for (int i = 0; i < WN; i++) begin
      if (pack_cnt_q == CW'(i)) begin
        commit_word[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
      end
    end
  end

  always_comb begin
    head_slice = head_word[RD_DATA_WIDTH-1:0];
    for (int i = 0; i < RN; i++) begin
      if (slice_q == CW'(i)) begin
        head_slice = head_word[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pack_cnt_d  = pack_cnt_q;
    slice_d     = slice_q;
    pack_buf_d  = pack_buf_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      pack_buf_d = commit_word;
      pack_cnt_d = commit ? '0 : pack_cnt_q + CW'(1);
    end
    if (commit) begin
      wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
    end

    if (rd_acc) begin
      rd_data_d = head_slice;
      slice_d   = pop ? '0 : slice_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
    end

    case ({commit, pop})
      2'b10:   count_d = count_q + (DEPTH_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase

    // A full-time write is lost even if a read frees a slot in the same cycle.
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pack_cnt_d  = '0;
      slice_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pack_cnt_q  <= '0;
      slice_q     <= '0;
      pack_buf_q  <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pack_cnt_q  <= pack_cnt_d;
      slice_q     <= slice_d;
      pack_buf_q  <= pack_buf_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; nothing reaches an output before it is written.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      mem[wr_ptr_q] <= commit_word;
    end
  end

  assign scaled_count = LW'(count_q) << LOG_N;

  always_comb begin
    if (UPSIZE) begin
      wr_water_level = scaled_count + LW'(pack_cnt_q);
      rd_water_level = LW'(count_q);
    end else if (DOWNSIZE) begin
      wr_water_level = LW'(count_q);
      rd_water_level = scaled_count - LW'(slice_q);
    end else begin
      wr_water_level = LW'(count_q);
      rd_water_level = LW'(count_q);
    end
  end

  assign wr_full      = full;
  assign rd_empty     = empty;
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign rd_data      = rd_data_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
